// File: rtl/shift_atanh_pla_pkg.sv
// shift_atanh_pla shared definitions: FSM state codes
// and Q-format defaults shared with the forward tanh PLA.
package shift_atanh_pla_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ABS   = 3'd1;
    localparam logic [2:0] ST_COUNT = 3'd2;
    localparam logic [2:0] ST_BUILD = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam int W_IN_DEF    = 8;
    localparam int W_OUT_DEF   = 8;
    localparam int OUT_I_DEF   = 4;
    localparam int SAT_SEG_DEF = 6;

endpackage

// File: rtl/shift_atanh_pla_if.sv
// Handshake bundle for shift_atanh_pla.
// slave: DUT side (in_* accepted, out_* produced); master: driver side.
interface shift_atanh_pla_if #(
    parameter int W_IN  = 8,
    parameter int W_OUT = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [W_IN-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [W_OUT-1:0] out_data;
    logic             out_sat;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/shift_atanh_pla_neg.sv
// shift_twos_neg: parameterised two's-complement negate.
// Ports: a (operand), y (-a, wraps for the most-negative code).
module shift_twos_neg #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    output logic [W-1:0] y
);
    assign y = ~a + {{(W-1){1'b0}}, 1'b1};
endmodule

// File: rtl/shift_atanh_pla.sv
// shift_atanh_pla: iterative shift-only inverse of the tanh PLA.
// Ports: clock, resetn (async low), bus (slave: in/out valid-ready).
module shift_atanh_pla
    import shift_atanh_pla_pkg::*;
#(
    parameter int W_IN    = W_IN_DEF,
    parameter int W_OUT   = W_OUT_DEF,
    parameter int OUT_I   = OUT_I_DEF,
    parameter int SAT_SEG = SAT_SEG_DEF
) (
    input logic            clock,
    input logic            resetn,
    shift_atanh_pla_if.slave bus
);
    localparam int OUT_F = W_OUT - OUT_I;
    localparam int CW    = $clog2(SAT_SEG + 1);
    localparam logic [CW-1:0] SAT_CNT = CW'(SAT_SEG);
    localparam logic [W_OUT-1:0] SAT_MAG =
        W_OUT'(SAT_SEG) << (OUT_F - 1);
    localparam logic [W_IN-1:0] MOST_NEG =
        {1'b1, {(W_IN-1){1'b0}}};

    logic [2:0]       state;
    logic [W_IN-1:0]  m;
    logic [W_IN-1:0]  m_neg;
    logic             sign;
    logic             sat;
    logic [CW-1:0]    cnt;
    logic [W_OUT-1:0] data_q;
    logic             sat_q;
    logic [W_OUT-1:0] x_mag;
    logic [W_OUT-1:0] x_neg;

    // After the scan the terminating 0 sits at bit -1, so r is
    // everything below it; r/2 gets a leading 0 then truncates.
    logic [W_IN+OUT_F-2:0] frac_w;
    logic [OUT_F-1:0]      r_half;

    assign frac_w = {1'b0, m[W_IN-3:0], {OUT_F{1'b0}}};
    assign r_half = frac_w[W_IN+OUT_F-2 -: OUT_F];

    always_comb begin
        x_mag = (W_OUT'(cnt) << (OUT_F - 1)) + W_OUT'(r_half);
        if (sat)
            x_mag = SAT_MAG;
    end

    shift_twos_neg #(.W(W_IN)) u_neg_in (
        .a (m),
        .y (m_neg)
    );

    shift_twos_neg #(.W(W_OUT)) u_neg_out (
        .a (x_mag),
        .y (x_neg)
    );

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.out_data  = data_q;
    assign bus.out_sat   = sat_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state  <= ST_IDLE;
            m      <= '0;
            sign   <= 1'b0;
            sat    <= 1'b0;
            cnt    <= '0;
            data_q <= '0;
            sat_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        m     <= bus.in_data;
                        sign  <= 1'b0;
                        sat   <= 1'b0;
                        cnt   <= '0;
                        state <= ST_ABS;
                    end
                end
                ST_ABS: begin
                    sign  <= m[W_IN-1];
                    m     <= m[W_IN-1] ? m_neg : m;
                    sat   <= (m == MOST_NEG);
                    state <= ST_COUNT;
                end
                ST_COUNT: begin
                    if (!sat && m[W_IN-2] && cnt < SAT_CNT) begin
                        cnt <= cnt + CW'(1);
                        m   <= m << 1;
                    end else begin
                        if (cnt == SAT_CNT)
                            sat <= 1'b1;
                        state <= ST_BUILD;
                    end
                end
                ST_BUILD: begin
                    data_q <= sign ? x_neg : x_mag;
                    sat_q  <= sat;
                    state  <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_atanh_pla.sv
// Scoreboard bench for shift_atanh_pla with directed vectors.
// Driver pushes expected results; a monitor pops on handshake.
module tb_shift_atanh_pla;

    typedef struct {
        logic [7:0] d;
        logic       s;
        int         due;
    } exp_t;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   hs_cyc = 0;
    int   acc_cyc = 0;
    logic prev_valid = 1'b0;
    exp_t q[$];
    exp_t cur;

    shift_atanh_pla_if #(.W_IN(8), .W_OUT(8)) bus ();

    shift_atanh_pla #(
        .W_IN(8), .W_OUT(8), .OUT_I(4), .SAT_SEG(6)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial forever #5 clock = ~clock;
    initial forever begin
        @(posedge clock);
        cyc++;
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic send(logic [7:0] y, logic [7:0] d,
                        logic s, int lat);
        int   n = 0;
        exp_t e;
        @(negedge clock);
        bus.in_valid = 1'b1;
        bus.in_data  = y;
        while (!bus.in_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("accept_timeout", int'(n < 100), 1);
        acc_cyc = cyc + 1;
        e.d = d;
        e.s = s;
        e.due = cyc + 1 + lat;
        q.push_back(e);
        @(negedge clock);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("drain_timeout", int'(n < 100), 1);
        repeat (2) @(negedge clock);
    endtask

    task automatic chk_reset();
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_sat", bus.out_sat, 0);
    endtask

    // Monitor: compares every valid cycle, latency on the rising one
    initial forever begin
        @(negedge clock);
        if (bus.out_valid) begin
            chk("in_ready_in_done", bus.in_ready, 0);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0h want none",
                         bus.out_data);
            end else begin
                cur = q[0];
                chk("out_data", bus.out_data, cur.d);
                chk("out_sat", bus.out_sat, cur.s);
                if (!prev_valid)
                    chk("latency", cyc, cur.due);
                if (bus.out_ready) begin
                    void'(q.pop_front());
                    hs_cyc = cyc + 1;
                end
            end
        end
        prev_valid = bus.out_valid;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] vin  [12] = '{8'h00, 8'h20, 8'h40, 8'h60,
                              8'hA0, 8'h80, 8'h7E, 8'h7F,
                              8'hE0, 8'h50, 8'h7C, 8'h30};
    logic [7:0] vout [12] = '{8'h00, 8'h04, 8'h08, 8'h10,
                              8'hF0, 8'hD0, 8'h30, 8'h30,
                              8'hFC, 8'h0C, 8'h28, 8'h06};
    logic       vsat [12] = '{0, 0, 0, 0, 0, 1, 1, 1,
                              0, 0, 0, 0};
    int         vlat [12] = '{3, 3, 4, 5, 5, 3, 9, 9,
                              3, 4, 8, 3};

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        #1;
        chk_reset();
        repeat (2) @(negedge clock);
        resetn = 1'b1;

        for (int i = 0; i < 12; i++)
            send(vin[i], vout[i], vsat[i], vlat[i]);
        drain();

        // Backpressure with a competing offer
        @(posedge clock);
        #2 bus.out_ready = 1'b0;
        send(8'h40, 8'h08, 1'b0, 4);
        for (int n = 0; n < 50 && !bus.out_valid; n++)
            @(negedge clock);
        chk("bp_valid_seen", bus.out_valid, 1);
        fork
            send(8'h20, 8'h04, 1'b0, 3);
            begin
                repeat (5) @(negedge clock);
                @(posedge clock);
                #2 bus.out_ready = 1'b1;
            end
        join
        chk("accept_after_hs", acc_cyc, hs_cyc + 1);
        drain();

        // Async reset mid-scan drops the in-flight result
        send(8'h60, 8'h10, 1'b0, 5);
        @(posedge clock);
        #3 resetn = 1'b0;
        #1;
        chk_reset();
        q.delete();
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        send(8'h40, 8'h08, 1'b0, 4);
        drain();

        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
